// File: rtl/kgp_isa_pkg.sv
// rtl/kgp_isa_pkg.sv - KGP-RISC instruction fields, opcodes, fcode classes and decoded entry type
package kgp_isa_pkg;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 29;
    localparam int RS_MSB     = 28;
    localparam int RS_LSB     = 24;
    localparam int RT_MSB     = 23;
    localparam int RT_LSB     = 19;
    localparam int SHAMT_MSB  = 18;
    localparam int SHAMT_LSB  = 14;
    localparam int IMM_MSB    = 21;
    localparam int IMM_LSB    = 0;
    localparam int FCODE_MSB  = 3;
    localparam int FCODE_LSB  = 0;

    localparam logic [2:0] OP_ALU_R = 3'd0;
    localparam logic [2:0] OP_ALU_I = 3'd1;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [4:0]  rs_idx;
        logic [4:0]  rt_idx;
        logic [4:0]  shamt;
        logic [21:0] imm;
        logic [3:0]  fcode;
        logic        rt_sel;
    } decoded_instr_t;

    // Register-register ALU functions; every other R-type fcode takes shamt.
    function automatic logic is_rt_fcode(input logic [3:0] fcode);
        case (fcode)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd9: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    function automatic logic is_illegal_fcode(input logic [3:0] fcode);
        return (fcode >= 4'd12);
    endfunction

endpackage

// File: rtl/instr_decode_stage_if.sv
// rtl/instr_decode_stage_if.sv - fetch-side and execute-side handshake bundle of the decode stage
interface instr_decode_stage_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [2:0]      out_opcode;
    logic [4:0]      out_rs_idx;
    logic [4:0]      out_rt_idx;
    logic [4:0]      out_shamt;
    logic [21:0]     out_imm;
    logic [3:0]      out_fcode;
    logic            out_rt_sel;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rs_idx, out_rt_idx,
               out_shamt, out_imm, out_fcode, out_rt_sel, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rs_idx, out_rt_idx,
               out_shamt, out_imm, out_fcode, out_rt_sel, out_illegal
    );

endinterface

// File: rtl/decode_skid_buf.sv
// rtl/decode_skid_buf.sv - generic 2-entry skid buffer with registered in_ready and flush
module decode_skid_buf
    import kgp_isa_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_t   state;
    buf_state_t   next_state;
    logic         in_ready_q;
    logic [W-1:0] slot0;
    logic [W-1:0] slot1;
    logic         accept;
    logic         take;
    logic         load0;
    logic         load1;
    logic         shift;

    assign in_ready  = in_ready_q;
    assign out_valid = (state != BUF_EMPTY);
    assign out_data  = slot0;
    assign accept    = in_valid & in_ready_q;
    assign take      = out_valid & out_ready;

    // Occupancy transitions; slot0 always holds the oldest entry.
    always_comb begin
        next_state = state;
        load0      = 1'b0;
        load1      = 1'b0;
        shift      = 1'b0;
        case (state)
            BUF_EMPTY: begin
                if (accept) begin
                    next_state = BUF_ONE;
                    load0      = 1'b1;
                end
            end
            BUF_ONE: begin
                if (accept && take) begin
                    load0 = 1'b1;
                end else if (accept) begin
                    next_state = BUF_TWO;
                    load1      = 1'b1;
                end else if (take) begin
                    next_state = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (take) begin
                    next_state = BUF_ONE;
                    shift      = 1'b1;
                end
            end
            default: next_state = BUF_EMPTY;
        endcase
        if (flush) begin
            next_state = BUF_EMPTY;
            load0      = 1'b0;
            load1      = 1'b0;
            shift      = 1'b0;
        end
    end

    // State and ready register; ready is derived from the next state so no out_ready path reaches fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BUF_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state      <= next_state;
            in_ready_q <= (next_state != BUF_TWO);
        end
    end

    // Entry storage; contents persist until overwritten or shifted forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            if (load0) begin
                slot0 <= in_data;
            end else if (shift) begin
                slot0 <= slot1;
            end
            if (load1) begin
                slot1 <= in_data;
            end
        end
    end

endmodule

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - KGP-RISC field decode into a skid buffer; optional DECODE_ILLEGAL_TRAP_EN
module instr_decode_stage
    import kgp_isa_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    instr_decode_stage_if.slave  bus
);

    decoded_instr_t dec;
    decoded_instr_t q_dec;
    logic [PC_W-1:0] q_pc;

    // Field split and operand-source classification on the incoming word.
    always_comb begin
        dec        = '0;
        dec.opcode = bus.in_instr[OPCODE_MSB:OPCODE_LSB];
        dec.rs_idx = bus.in_instr[RS_MSB:RS_LSB];
        if (dec.opcode == OP_ALU_R) begin
            dec.rt_idx = bus.in_instr[RT_MSB:RT_LSB];
            dec.shamt  = bus.in_instr[SHAMT_MSB:SHAMT_LSB];
            dec.fcode  = bus.in_instr[FCODE_MSB:FCODE_LSB];
            dec.rt_sel = is_rt_fcode(bus.in_instr[FCODE_MSB:FCODE_LSB]);
        end
        if (dec.opcode == OP_ALU_I) begin
            dec.imm = bus.in_instr[IMM_MSB:IMM_LSB];
        end
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    localparam int PAY_W = PC_W + $bits(decoded_instr_t) + 1;

    logic             illegal_in;
    logic             q_illegal;
    logic             illegal_seen;
    logic [PAY_W-1:0] pay_in;
    logic [PAY_W-1:0] pay_out;

    assign illegal_in = (dec.opcode == OP_ALU_R) && is_illegal_fcode(dec.fcode);
    assign pay_in     = {bus.in_pc, dec, illegal_in};
    assign {q_pc, q_dec, q_illegal} = pay_out;
    assign bus.out_illegal = q_illegal;

    // Sticky record of any illegal encoding accepted since reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_seen <= 1'b0;
        end else if (bus.in_valid && bus.in_ready && illegal_in) begin
            illegal_seen <= 1'b1;
        end
    end
`else
    localparam int PAY_W = PC_W + $bits(decoded_instr_t);

    logic [PAY_W-1:0] pay_in;
    logic [PAY_W-1:0] pay_out;

    assign pay_in  = {bus.in_pc, dec};
    assign {q_pc, q_dec} = pay_out;
    assign bus.out_illegal = 1'b0;
`endif

    decode_skid_buf #(
        .W(PAY_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (pay_in),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (pay_out)
    );

    assign bus.out_pc     = q_pc;
    assign bus.out_opcode = q_dec.opcode;
    assign bus.out_rs_idx = q_dec.rs_idx;
    assign bus.out_rt_idx = q_dec.rt_idx;
    assign bus.out_shamt  = q_dec.shamt;
    assign bus.out_imm    = q_dec.imm;
    assign bus.out_fcode  = q_dec.fcode;
    assign bus.out_rt_sel = q_dec.rt_sel;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - directed self-checking bench for instr_decode_stage
module tb_instr_decode_stage;

    logic clk;
    logic rst_n;
    logic flush;
    int   n_checks;
    int   n_pass;

    instr_decode_stage_if #(.PC_W(32)) dif ();

    instr_decode_stage #(.PC_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        dif.in_valid = 1'b1;
        dif.in_instr = instr;
        dif.in_pc    = pc;
    endtask

    task automatic idle();
        dif.in_valid = 1'b0;
        dif.in_instr = '0;
        dif.in_pc    = '0;
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        flush         = 1'b0;
        dif.out_ready = 1'b0;
        idle();

        // reset state
        #12;
        check("rst_out_valid", dif.out_valid, 0);
        check("rst_in_ready", dif.in_ready, 0);
        check("rst_out_pc", dif.out_pc, 0);
        check("rst_illegal", dif.out_illegal, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        #2;
        check("rel_in_ready_before_edge", dif.in_ready, 0);
        tick();
        check("rel_in_ready", dif.in_ready, 1);
        check("rel_out_valid", dif.out_valid, 0);

        // R-type reg-reg: rs=3 rt=5 fcode=2
        dif.out_ready = 1'b1;
        send(32'h0328_0002, 32'h100);
        tick();
        idle();
        check("r_valid", dif.out_valid, 1);
        check("r_pc", dif.out_pc, 32'h100);
        check("r_opcode", dif.out_opcode, 0);
        check("r_rs", dif.out_rs_idx, 3);
        check("r_rt", dif.out_rt_idx, 5);
        check("r_fcode", dif.out_fcode, 2);
        check("r_rt_sel", dif.out_rt_sel, 1);
        check("r_imm", dif.out_imm, 0);
        tick();
        check("r_drained", dif.out_valid, 0);

        // I-type: rs=7 imm=0x200001, raw rt bits non-zero but forced to 0
        send(32'h2720_0001, 32'h104);
        tick();
        idle();
        check("i_opcode", dif.out_opcode, 1);
        check("i_rs", dif.out_rs_idx, 7);
        check("i_imm", dif.out_imm, 22'h200001);
        check("i_rt", dif.out_rt_idx, 0);
        check("i_shamt", dif.out_shamt, 0);
        check("i_fcode", dif.out_fcode, 0);
        check("i_rt_sel", dif.out_rt_sel, 0);
        tick();

        // shift type: rs=2 rt=1 shamt=7 fcode=4
        send(32'h0209_C004, 32'h108);
        tick();
        idle();
        check("s_shamt", dif.out_shamt, 7);
        check("s_rt", dif.out_rt_idx, 1);
        check("s_rt_sel", dif.out_rt_sel, 0);
        check("s_fcode", dif.out_fcode, 4);
        tick();

        // fcode 9 is reg-reg
        send(32'h0000_0009, 32'h10C);
        tick();
        idle();
        check("f9_rt_sel", dif.out_rt_sel, 1);
        tick();

        // opcode 5: everything but opcode/rs zeroed
        send(32'hBFFF_FFFF, 32'h110);
        tick();
        idle();
        check("o5_opcode", dif.out_opcode, 5);
        check("o5_rs", dif.out_rs_idx, 5'h1F);
        check("o5_rt", dif.out_rt_idx, 0);
        check("o5_shamt", dif.out_shamt, 0);
        check("o5_imm", dif.out_imm, 0);
        check("o5_fcode", dif.out_fcode, 0);
        check("o5_rt_sel", dif.out_rt_sel, 0);
        tick();

        // illegal fcode 13
        send(32'h0100_000D, 32'h114);
        tick();
        idle();
        check("ill_rt_sel", dif.out_rt_sel, 0);
        check("ill_fcode", dif.out_fcode, 13);
`ifdef DECODE_ILLEGAL_TRAP_EN
        check("ill_flag", dif.out_illegal, 1);
`else
        check("ill_flag", dif.out_illegal, 0);
`endif
        tick();

        // three back-to-back with out_ready low
        dif.out_ready = 1'b0;
        send(32'h0100_0000, 32'h200);
        tick();
        check("bb_ready_after1", dif.in_ready, 1);
        send(32'h0200_0000, 32'h204);
        tick();
        check("bb_ready_after2", dif.in_ready, 0);
        send(32'h0300_0000, 32'h208);
        tick();
        check("bb_held_ready", dif.in_ready, 0);
        check("bb_held_pc", dif.out_pc, 32'h200);
        dif.out_ready = 1'b1;
        #1;
        check("bb_pc0", dif.out_pc, 32'h200);
        check("bb_rs0", dif.out_rs_idx, 1);
        tick();
        check("bb_pc1", dif.out_pc, 32'h204);
        check("bb_rs1", dif.out_rs_idx, 2);
        check("bb_ready_reopen", dif.in_ready, 1);
        tick();
        idle();
        check("bb_pc2", dif.out_pc, 32'h208);
        check("bb_rs2", dif.out_rs_idx, 3);
        check("bb_valid2", dif.out_valid, 1);
        tick();
        check("bb_drained", dif.out_valid, 0);

        // flush in ONE with a live input: input dropped
        dif.out_ready = 1'b0;
        send(32'h0400_0000, 32'h300);
        tick();
        flush = 1'b1;
        send(32'h0500_0000, 32'h304);
        tick();
        flush = 1'b0;
        idle();
        check("fl1_valid", dif.out_valid, 0);
        check("fl1_ready", dif.in_ready, 1);

        // flush in TWO
        send(32'h0600_0000, 32'h310);
        tick();
        send(32'h0700_0000, 32'h314);
        tick();
        check("fl2_full", dif.in_ready, 0);
        flush = 1'b1;
        send(32'h0800_0000, 32'h318);
        tick();
        flush = 1'b0;
        idle();
        check("fl2_valid", dif.out_valid, 0);
        check("fl2_ready", dif.in_ready, 1);
        tick();
        check("fl2_dropped", dif.out_valid, 0);

        // async reset while TWO
        send(32'h0900_0000, 32'h400);
        tick();
        send(32'h0A00_0000, 32'h404);
        tick();
        idle();
        check("ar_pre_valid", dif.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("ar_valid", dif.out_valid, 0);
        check("ar_pc", dif.out_pc, 0);
        check("ar_rs", dif.out_rs_idx, 0);
        check("ar_ready", dif.in_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("ar_rel_ready", dif.in_ready, 1);
        check("ar_rel_valid", dif.out_valid, 0);
        send(32'h0B28_0003, 32'h500);
        tick();
        idle();
        check("ar_first_valid", dif.out_valid, 1);
        check("ar_first_pc", dif.out_pc, 32'h500);
        check("ar_first_rs", dif.out_rs_idx, 11);
        check("ar_first_rt", dif.out_rt_idx, 5);
        check("ar_first_ready", dif.in_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
